id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between instruction decode and execute. Captures the decoder's control bundle (RegDst, Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite) together with operand data, register indices, immediate and PC+4. Presents them to the ALU/EX stage one cycle later. Also handles bubble insertion for stalls and flushes, and load-use hazard detection.

## Interface
- DATA_W, 32, datapath width (PC, register data, extended immediate)
- REG_W, 5, register index width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  external hold (e.g. memory wait); ID/EX keeps its contents
- flush_i  in  1  branch taken in EX; kill the instruction entering ID/EX
- id_valid_i  in  1  decode slot holds a real instruction
- id_RegDst, id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  decoder controls
- id_ALUOp  in  3  decoder ALU operation class
- id_pc4_i  in  DATA_W  PC+4 of decoded instruction
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data
- id_imm16_i  in  16  raw immediate
- id_rs_i, id_rt_i, id_rd_i  in  REG_W  register indices
- id_funct_i  in  6  funct field for ALU control
- ex_* outputs  out  same widths  registered copies of every id_* control/data/index input above
- ex_imm32_o  out  DATA_W  sign-extended immediate
- ex_valid_o  out  1  EX slot holds a real instruction
- hazard_stall_o  out  1  load-use detected; PC and IF/ID must hold this cycle

## Operation
- Register update priority each cycle, highest first:
  1. rst_n=0
  2. flush_i → bubble
  3. stall_i → hold all
  4. hazard_stall_o → bubble
  5. load
- Bubble: ex_valid_o=0; all eight control outputs = 0 (ALUOp=3'b000); data/index registers hold their previous value. Downstream must rely only on the controls and valid.
- Load:
  - If id_valid_i=1, capture every input; ex_valid_o=1.
  - If id_valid_i=0, load a bubble.
  - Control inputs carrying X, or decoder outputs for undecoded opcodes, are not filtered. Gating is by id_valid_i only.
- Sign extension: ex_imm32_o = {{(DATA_W-16){imm16[15]}}, imm16}. Computed before the register and stored.
- Load-use detection (combinational, from ex_* state and id_* inputs): hazard_stall_o = ex_valid_o & ex_MemRead & (ex_rt != 0) & id_valid_i & ((ex_rt == id_rs_i) | (ex_rt == id_rt_i)).
- flush_i and stall_i are both don't-care for hazard_stall_o. The output is asserted regardless; upstream ORs it with its own stall.

## Timing
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Reset values (asynchronous, all outputs): all ex_* = 0, ex_valid_o = 0. hazard_stall_o is therefore 0.
- Load-use stall is exactly one cycle. The bubble clears ex_MemRead, so hazard_stall_o deasserts on the next cycle and the held instruction loads.
- Simultaneous events:
  - flush_i & stall_i → flush wins.
  - stall_i & hazard → hold; the hazard persists and resolves after stall_i drops.
- Reset asserted mid-stream discards in-flight contents immediately (asynchronous). First load occurs on the first edge after rst_n rises.
- hazard_stall_o has no register. It is valid in the same cycle as the id_* inputs.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection as above.
- ID_EX_HAZARD_EN undefined: hazard_stall_o tied 0 and priority step 4 absent. Software must schedule a NOP after each load whose destination is used next.

## Structure
- Shared package cpu_pkg holds:
  - ALUOP_W=3, REG_W=5, FUNCT_W=6
  - ctrl_t packed struct of the 10 control bits
  - CTRL_BUBBLE constant (all zero)
- Stage register uses ctrl_t internally; ports stay flat.
- One sub-module, hazard_unit: purely combinational load-use compare. Instantiated only under ID_EX_HAZARD_EN.

## Test plan
- Reset: drive inputs non-zero, pulse rst_n low mid-cycle → all ex_* = 0 and ex_valid_o=0 immediately, with no clock edge needed.
- ADDI pass-through: id_ALUSrc=1, id_RegWrite=1, id_ALUOp=000, imm16=16'hFFFC, rt=9 → next cycle ex_imm32_o=32'hFFFFFFFC, ex_rt=9, ex_valid_o=1.
- Load-use: lw rt=8 in EX (MemRead=1), ID has rs=8 → hazard_stall_o=1 that cycle. Next cycle ex_valid_o=0 with all controls 0, hazard_stall_o=0. The following cycle the dependent instruction appears in EX.
- $zero exemption: lw rt=0 in EX, ID rs=0 → hazard_stall_o=0 and normal load.
- Flush beats stall: flush_i=1 and stall_i=1 with a valid R-type in ID → next cycle ex_valid_o=0, ex_RegWrite=0.
- External stall: stall_i=1 for 3 cycles while ID changes → ex_* unchanged throughout. The ID value present when stall_i drops loads on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: the decoder control bundle carried through ID/EX and common field widths.
package cpu_pkg;
    localparam int ALUOP_W = 3;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;

    typedef struct packed {
        logic               regDst;
        logic               branch;
        logic               memRead;
        logic               memToReg;
        logic [ALUOP_W-1:0] aluOp;
        logic               memWrite;
        logic               aluSrc;
        logic               regWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side inputs, execute-side registered outputs, stall/flush and hazard.
interface id_ex_if #(parameter int DATA_W = 32, parameter int REG_W = 5);
    import cpu_pkg::*;

    logic stall_i, flush_i, id_valid_i;
    logic id_RegDst, id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic [DATA_W-1:0]  id_pc4_i, id_rs_data_i, id_rt_data_i;
    logic [15:0]        id_imm16_i;
    logic [REG_W-1:0]   id_rs_i, id_rt_i, id_rd_i;
    logic [FUNCT_W-1:0] id_funct_i;

    logic ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic [DATA_W-1:0]  ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm32_o;
    logic [REG_W-1:0]   ex_rs_o, ex_rt_o, ex_rd_o;
    logic [FUNCT_W-1:0] ex_funct_o;
    logic               ex_valid_o, hazard_stall_o;

    modport master (
        output stall_i, flush_i, id_valid_i,
               id_RegDst, id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite,
               id_ALUOp, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm16_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        input  ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
               ex_ALUOp, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm32_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, ex_valid_o, hazard_stall_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i,
               id_RegDst, id_Branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite,
               id_ALUOp, id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm16_i,
               id_rs_i, id_rt_i, id_rd_i, id_funct_i,
        output ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
               ex_ALUOp, ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm32_o,
               ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o, ex_valid_o, hazard_stall_o
    );
endinterface

// File: rtl/id_ex_stage_hazard.sv
// hazard_unit: combinational load-use compare between the load in EX and the instruction in ID.
module hazard_unit import cpu_pkg::*; (
    input  logic             exValid,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRt,
    input  logic             idValid,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    output logic             hazard
);
    // $zero never carries a dependency, so a load targeting r0 never stalls.
    assign hazard = exValid & exMemRead & (exRt != '0) & idValid &
                    ((exRt == idRs) | (exRt == idRt));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall/bubble handling.
// Load-use detection is built only when ID_EX_HAZARD_EN is defined; otherwise hazard_stall_o is 0.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    import cpu_pkg::*;

    ctrl_t idCtrl, exCtrl;
    logic  exValid, hazard;
    logic [DATA_W-1:0]  exPc4, exRsData, exRtData, exImm32, idImm32;
    logic [REG_W-1:0]   exRs, exRt, exRd;
    logic [FUNCT_W-1:0] exFunct;

    assign idCtrl = '{regDst: bus.id_RegDst, branch: bus.id_Branch, memRead: bus.id_MemRead,
                      memToReg: bus.id_MemToReg, aluOp: bus.id_ALUOp, memWrite: bus.id_MemWrite,
                      aluSrc: bus.id_ALUSrc, regWrite: bus.id_RegWrite};
    assign idImm32 = {{(DATA_W-16){bus.id_imm16_i[15]}}, bus.id_imm16_i};

`ifdef ID_EX_HAZARD_EN
    hazard_unit uHazard (
        .exValid   (exValid),
        .exMemRead (exCtrl.memRead),
        .exRt      (exRt),
        .idValid   (bus.id_valid_i),
        .idRs      (bus.id_rs_i),
        .idRt      (bus.id_rt_i),
        .hazard    (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    // Bubbles clear only controls and valid; data fields keep stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exCtrl   <= CTRL_BUBBLE;
            exValid  <= 1'b0;
            exPc4    <= '0;
            exRsData <= '0;
            exRtData <= '0;
            exImm32  <= '0;
            exRs     <= '0;
            exRt     <= '0;
            exRd     <= '0;
            exFunct  <= '0;
        end else if (bus.flush_i) begin
            exCtrl  <= CTRL_BUBBLE;
            exValid <= 1'b0;
        end else if (bus.stall_i) begin
            exCtrl  <= exCtrl;
            exValid <= exValid;
        end else if (hazard || !bus.id_valid_i) begin
            exCtrl  <= CTRL_BUBBLE;
            exValid <= 1'b0;
        end else begin
            exCtrl   <= idCtrl;
            exValid  <= 1'b1;
            exPc4    <= bus.id_pc4_i;
            exRsData <= bus.id_rs_data_i;
            exRtData <= bus.id_rt_data_i;
            exImm32  <= idImm32;
            exRs     <= bus.id_rs_i;
            exRt     <= bus.id_rt_i;
            exRd     <= bus.id_rd_i;
            exFunct  <= bus.id_funct_i;
        end
    end

    assign bus.ex_RegDst      = exCtrl.regDst;
    assign bus.ex_Branch      = exCtrl.branch;
    assign bus.ex_MemRead     = exCtrl.memRead;
    assign bus.ex_MemToReg    = exCtrl.memToReg;
    assign bus.ex_ALUOp       = exCtrl.aluOp;
    assign bus.ex_MemWrite    = exCtrl.memWrite;
    assign bus.ex_ALUSrc      = exCtrl.aluSrc;
    assign bus.ex_RegWrite    = exCtrl.regWrite;
    assign bus.ex_pc4_o       = exPc4;
    assign bus.ex_rs_data_o   = exRsData;
    assign bus.ex_rt_data_o   = exRtData;
    assign bus.ex_imm32_o     = exImm32;
    assign bus.ex_rs_o        = exRs;
    assign bus.ex_rt_o        = exRt;
    assign bus.ex_rd_o        = exRd;
    assign bus.ex_funct_o     = exFunct;
    assign bus.ex_valid_o     = exValid;
    assign bus.hazard_stall_o = hazard;
endmodule
